// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and strobe sequencer for the 32-bit data SRAM (four 8-bit chips),
// shared between the CPU load/store path (port C) and the host loader/debug port (port H).
module dmem_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [3:0]    c_be_n,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_ack,
    output logic [31:0]   c_rdata,
    output logic          c_stall,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [3:0]    h_be_n,
    input  logic [AW-1:0] h_addr,
    input  logic [31:0]   h_wdata,
    output logic          h_ack,
    output logic [31:0]   h_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [3:0]    sram_ce_n,
    output logic          sram_oe_n,
    output logic [3:0]    sram_we_n,
    output logic [31:0]   sram_dout,
    output logic          sram_dout_en,
    input  logic [31:0]   sram_din
);

    // state  | meaning
    // IDLE   | no access in flight; arbitrate between c_req and h_req
    // SETUP  | address and chip enables valid; oe low (read) or data driven (write)
    // ACCESS | WAIT_CYCLES strobe cycles; read data captured on the last one
    // DONE   | we released while addr/ce/data held; owner acked

    localparam logic       PORT_C      = 1'b0;
    localparam logic       PORT_H      = 1'b1;
    localparam logic [3:0] ACCESS_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner;
    logic          last_grant;
    logic          grant_h;
    logic          grant_vld;
    logic          last_access;
    logic          lat_we;
    logic [3:0]    lat_be_n;
    logic [3:0]    cnt;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;

    // On a tie the port that did not win last time gets the SRAM.
    assign grant_vld   = c_req | h_req;
    assign grant_h     = h_req & (~c_req | (last_grant == PORT_C));
    assign last_access = (state == ACCESS) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= PORT_C;
            last_grant <= PORT_H;
            lat_we     <= 1'b0;
            lat_be_n   <= 4'hF;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (state == IDLE && grant_vld) begin
            owner      <= grant_h;
            last_grant <= grant_h;
            lat_we     <= grant_h ? h_we    : c_we;
            lat_be_n   <= grant_h ? h_be_n  : c_be_n;
            lat_addr   <= grant_h ? h_addr  : c_addr;
            lat_wdata  <= grant_h ? h_wdata : c_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (state == SETUP) begin
            cnt <= ACCESS_LOAD;
        end else if (state == ACCESS && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rdata <= '0;
            h_rdata <= '0;
        end else if (last_access && !lat_we) begin
            if (owner == PORT_H) h_rdata <= sram_din;
            else                 c_rdata <= sram_din;
        end
    end

    // Strobes decode from registered state so an async reset kills them immediately.
    always_comb begin
        sram_ce_n    = 4'hF;
        sram_oe_n    = 1'b1;
        sram_we_n    = 4'hF;
        sram_dout_en = 1'b0;
        c_ack        = 1'b0;
        h_ack        = 1'b0;
        case (state)
            SETUP: begin
                sram_ce_n    = lat_we ? lat_be_n : 4'h0;
                sram_oe_n    = lat_we;
                sram_dout_en = lat_we;
            end
            ACCESS: begin
                sram_ce_n    = lat_we ? lat_be_n : 4'h0;
                sram_oe_n    = lat_we;
                sram_dout_en = lat_we;
                if (lat_we) sram_we_n = lat_be_n;
            end
            DONE: begin
                sram_ce_n    = lat_we ? lat_be_n : 4'h0;
                sram_dout_en = lat_we;
                c_ack        = (owner == PORT_C);
                h_ack        = (owner == PORT_H);
            end
            default: begin
                sram_ce_n = 4'hF;
            end
        endcase
    end

    assign sram_addr = lat_addr;
    assign sram_dout = lat_wdata;
    assign c_stall   = c_req & ~c_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, hand sequences for reset/arbitration corners, and
// random two-port traffic checked against a transaction-level memory model.
module tb_dmem_arbiter;

    localparam int W  = 2;
    localparam int AW = 15;

    logic          clk;
    logic          rst_n;
    logic          c_req, c_we, c_ack, c_stall;
    logic [3:0]    c_be_n;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdata, c_rdata;
    logic          h_req, h_we, h_ack;
    logic [3:0]    h_be_n;
    logic [AW-1:0] h_addr;
    logic [31:0]   h_wdata, h_rdata;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_ce_n, sram_we_n;
    logic          sram_oe_n, sram_dout_en;
    logic [31:0]   sram_dout, sram_din;

    dmem_arbiter #(.WAIT_CYCLES(W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_be_n(c_be_n), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_stall(c_stall),
        .h_req(h_req), .h_we(h_we), .h_be_n(h_be_n), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
        .sram_din(sram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin-level SRAM: per-lane write while ce and we are low, read while ce and oe are low.
    bit   [31:0] sram_mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            sram_mem[pl_addr] <= pl_data;
        end else begin
            for (int i = 0; i < 4; i++)
                if (!sram_ce_n[i] && !sram_we_n[i] && sram_dout_en)
                    sram_mem[sram_addr[7:0]][8*i +: 8] <= sram_dout[8*i +: 8];
        end
    end
    assign sram_din = (sram_ce_n == 4'h0 && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 32'h0;

    int          total = 0;
    int          bad   = 0;
    bit   [31:0] ref_mem [0:255];
    logic [31:0] exp_rdata [0:1];

    typedef struct {
        int          port;
        logic        we;
        logic [3:0]  be_n;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic        pre_en;
        logic [31:0] pre;
        logic [31:0] exp_rd;
        int          exp_we_cyc;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
        end
    endtask

    task automatic ref_write(input logic [14:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (!be[i]) ref_mem[a[7:0]][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic drive(input int p, input logic req, input logic we, input logic [3:0] be,
                         input logic [14:0] a, input logic [31:0] d);
        if (p == 0) begin
            c_req = req; c_we = we; c_be_n = be; c_addr = a; c_wdata = d;
        end else begin
            h_req = req; h_we = we; h_be_n = be; h_addr = a; h_wdata = d;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? c_ack : h_ack;
    endfunction

    function automatic logic stall_of(input int p);
        return (p == 0) ? c_stall : (h_req & ~h_ack);
    endfunction

    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? c_rdata : h_rdata;
    endfunction

    task automatic preload(input logic [14:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a[7:0]; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a[7:0]] = d;
    endtask

    // One isolated access; pin expectations follow the phase: 1 = SETUP, 2..W+1 = ACCESS, W+2 = DONE.
    task automatic run_vec(input vec_t v);
        int          n, we_cyc, pin_err, stall_err;
        logic        got, ce_chk, e_oe, e_den;
        logic [3:0]  e_ce, e_we;
        logic [31:0] rd_ack;
        n = 0; we_cyc = 0; pin_err = 0; stall_err = 0; got = 1'b0; rd_ack = 32'h0;
        if (v.pre_en) preload(v.addr, v.pre);
        drive(v.port, 1'b1, v.we, v.be_n, v.addr, v.wdata);
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            e_ce = 4'hF; e_we = 4'hF; e_oe = 1'b1; e_den = 1'b0; ce_chk = 1'b1;
            if (n <= W + 2) begin
                e_ce  = v.we ? v.be_n : 4'h0;
                e_den = v.we;
                if (n <= W + 1) e_oe = v.we;
                if (v.we && n >= 2 && n <= W + 1) e_we = v.be_n;
                if (!v.we && n == W + 2) ce_chk = 1'b0;
                if (sram_addr !== v.addr) pin_err++;
                if (v.we && sram_dout !== v.wdata) pin_err++;
            end
            if ((ce_chk && sram_ce_n !== e_ce) || sram_we_n !== e_we ||
                sram_oe_n !== e_oe || sram_dout_en !== e_den) pin_err++;
            if (sram_we_n !== 4'hF) we_cyc++;
            if (ack_of(1 - v.port)) pin_err++;
            if (ack_of(v.port)) begin
                got = 1'b1;
                rd_ack = rdata_of(v.port);
                if (stall_of(v.port) !== 1'b0) stall_err++;
            end else if (stall_of(v.port) !== 1'b1) begin
                stall_err++;
            end
        end
        drive(v.port, 1'b0, v.we, v.be_n, v.addr, v.wdata);
        check("vec_latency", 32'(n), 32'(W + 2));
        check("vec_pins", 32'(pin_err), 32'h0);
        check("vec_we_cycles", 32'(we_cyc), 32'(v.exp_we_cyc));
        check("vec_stall", 32'(stall_err), 32'h0);
        if (v.we) ref_write(v.addr, v.be_n, v.wdata);
        else      exp_rdata[v.port] = v.exp_rd;
        check("vec_rdata", rd_ack, exp_rdata[v.port]);
        check("vec_other_rdata", rdata_of(1 - v.port), exp_rdata[1 - v.port]);
        @(negedge clk);
        check("vec_ack_single", 32'(c_ack | h_ack), 32'h0);
        check("vec_rdata_hold", rdata_of(v.port), exp_rdata[v.port]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, k, dual, acks, c_cnt, c_n, h_n, cyc, contention, spurious, stall_err, hold_err, done;
        int   ack_port [3];
        int   ack_n    [3];
        bit   act [2];
        int   age [2];
        int   gap [2];
        logic        r_we   [2];
        logic [3:0]  r_be   [2];
        logic [14:0] r_addr [2];
        logic [31:0] r_wd   [2];

        vecs[0] = '{0, 1'b1, 4'b1100, 15'h12, 32'hA5A5A5A5, 1'b0, 32'h0,        32'h0,        2};
        vecs[1] = '{0, 1'b0, 4'h0,    15'h12, 32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 0};
        vecs[2] = '{1, 1'b1, 4'hF,    15'h20, 32'hFFFFFFFF, 1'b1, 32'h11223344, 32'h0,        0};
        vecs[3] = '{1, 1'b0, 4'h0,    15'h20, 32'h0,        1'b0, 32'h0,        32'h11223344, 0};
        vecs[4] = '{0, 1'b1, 4'b0110, 15'h12, 32'h12345678, 1'b0, 32'h0,        32'h0,        2};
        vecs[5] = '{1, 1'b0, 4'h0,    15'h12, 32'h0,        1'b0, 32'h0,        32'h12ADBE78, 0};

        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        pl_en = 1'b0; pl_addr = 8'h0; pl_data = 32'h0;
        drive(0, 1'b0, 1'b0, 4'hF, 15'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'hF, 15'h0, 32'h0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ce_n", 32'(sram_ce_n), 32'hF);
        check("reset_we_n", 32'(sram_we_n), 32'hF);
        check("reset_oe_dout_en", {30'b0, sram_oe_n, sram_dout_en}, 32'h2);
        check("reset_addr", 32'(sram_addr), 32'h0);
        check("reset_dout", sram_dout, 32'h0);
        check("reset_acks", 32'({c_ack, h_ack}), 32'h0);
        check("reset_rdata", c_rdata | h_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted in the middle of a write's ACCESS phase.
        drive(0, 1'b1, 1'b1, 4'h0, 15'h40, 32'h5555AAAA);
        repeat (2) @(negedge clk);
        check("rst_mid_we_before", 32'(sram_we_n), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_we_n", 32'(sram_we_n), 32'hF);
        check("rst_mid_ce_n", 32'(sram_ce_n), 32'hF);
        check("rst_mid_dout_en", 32'(sram_dout_en), 32'h0);
        check("rst_mid_ack", 32'(c_ack), 32'h0);
        check("rst_mid_addr", 32'(sram_addr), 32'h0);
        drive(0, 1'b0, 1'b0, 4'hF, 15'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (c_ack || h_ack) acks++;
        end
        check("rst_mid_no_ack", 32'(acks), 32'h0);

        // Simultaneous requests held for three accesses: C, H, C with one IDLE cycle between.
        preload(15'h31, 32'hCAFE0031);
        drive(0, 1'b1, 1'b1, 4'h0, 15'h30, 32'h0BADF00D);
        drive(1, 1'b1, 1'b0, 4'h0, 15'h31, 32'h0);
        n = 0; k = 0; dual = 0;
        for (int i = 0; i < 3; i++) begin ack_port[i] = -1; ack_n[i] = 0; end
        while (k < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (c_ack && h_ack) dual++;
            if (c_ack) begin ack_port[k] = 0; ack_n[k] = n; k++; end
            else if (h_ack) begin
                ack_port[k] = 1; ack_n[k] = n; k++;
                exp_rdata[1] = ref_mem[8'h31];
                check("rr_h_rdata", h_rdata, exp_rdata[1]);
            end
        end
        drive(0, 1'b0, 1'b0, 4'hF, 15'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'hF, 15'h0, 32'h0);
        ref_write(15'h30, 4'h0, 32'h0BADF00D);
        check("rr_ack_count", 32'(k), 32'h3);
        check("rr_order0", 32'(ack_port[0]), 32'h0);
        check("rr_order1", 32'(ack_port[1]), 32'h1);
        check("rr_order2", 32'(ack_port[2]), 32'h0);
        check("rr_ack0_cycle", 32'(ack_n[0]), 32'(W + 2));
        check("rr_ack1_cycle", 32'(ack_n[1]), 32'(2 * W + 5));
        check("rr_ack2_cycle", 32'(ack_n[2]), 32'(3 * W + 8));
        check("rr_dual_ack", 32'(dual), 32'h0);
        acks = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (c_ack || h_ack) acks++;
        end
        check("rr_no_extra_ack", 32'(acks), 32'h0);
        check("rr_c_rdata", c_rdata, exp_rdata[0]);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // C drops its request during SETUP while H starts requesting.
        drive(0, 1'b1, 1'b0, 4'h0, 15'h12, 32'h0);
        n = 0; c_cnt = 0; c_n = 0; h_n = 0;
        while (h_n == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (c_ack) begin c_cnt++; c_n = n; end
            if (h_ack) h_n = n;
            if (n == 1) begin
                drive(0, 1'b0, 1'b0, 4'h0, 15'h12, 32'h0);
                drive(1, 1'b1, 1'b0, 4'h0, 15'h20, 32'h0);
            end
        end
        drive(1, 1'b0, 1'b0, 4'hF, 15'h0, 32'h0);
        exp_rdata[0] = ref_mem[8'h12];
        exp_rdata[1] = ref_mem[8'h20];
        check("drop_c_ack_count", 32'(c_cnt), 32'h1);
        check("drop_c_ack_cycle", 32'(c_n), 32'(W + 2));
        check("drop_h_ack_cycle", 32'(h_n), 32'(2 * W + 5));
        check("drop_c_rdata", c_rdata, exp_rdata[0]);
        check("drop_h_rdata", h_rdata, exp_rdata[1]);
        @(negedge clk);

        // Random two-port traffic against the transaction-level memory model.
        cyc = 0; contention = 0; spurious = 0; stall_err = 0; hold_err = 0; done = 0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; age[p] = 0; gap[p] = 0;
            r_we[p] = 1'b0; r_be[p] = 4'hF; r_addr[p] = 15'h0; r_wd[p] = 32'h0;
        end
        while (cyc < 700 && (cyc < 500 || act[0] || act[1])) begin
            @(negedge clk);
            cyc++;
            if (sram_dout_en && !sram_oe_n) contention++;
            for (int p = 0; p < 2; p++) begin
                if (ack_of(p)) begin
                    if (stall_of(p) !== 1'b0) stall_err++;
                    if (!act[p]) begin
                        spurious++;
                    end else begin
                        if (r_we[p]) begin
                            ref_write(r_addr[p], r_be[p], r_wd[p]);
                        end else begin
                            check("rand_rdata", rdata_of(p), ref_mem[r_addr[p][7:0]]);
                            exp_rdata[p] = ref_mem[r_addr[p][7:0]];
                        end
                        done++;
                        act[p] = 1'b0;
                        gap[p] = int'($urandom_range(0, 3));
                        drive(p, 1'b0, 1'b0, 4'hF, 15'h0, 32'h0);
                    end
                end else if (act[p]) begin
                    if (stall_of(p) !== 1'b1) stall_err++;
                    age[p]++;
                    if (age[p] > 40) begin
                        check("rand_timeout", 32'(age[p]), 32'h0);
                        act[p] = 1'b0;
                        drive(p, 1'b0, 1'b0, 4'hF, 15'h0, 32'h0);
                    end
                end else begin
                    if (stall_of(p) !== 1'b0) stall_err++;
                    if (cyc < 500) begin
                        if (gap[p] > 0) begin
                            gap[p]--;
                        end else if ($urandom_range(0, 1) == 1) begin
                            r_we[p]   = 1'($urandom_range(0, 1));
                            r_be[p]   = 4'($urandom_range(0, 15));
                            r_addr[p] = 15'($urandom_range(0, 7));
                            r_wd[p]   = $urandom;
                            act[p]    = 1'b1;
                            age[p]    = 0;
                            drive(p, 1'b1, r_we[p], r_be[p], r_addr[p], r_wd[p]);
                        end
                    end
                end
            end
            if (c_rdata !== exp_rdata[0] || h_rdata !== exp_rdata[1]) hold_err++;
        end
        check("rand_contention", 32'(contention), 32'h0);
        check("rand_spurious_ack", 32'(spurious), 32'h0);
        check("rand_stall", 32'(stall_err), 32'h0);
        check("rand_rdata_hold", 32'(hold_err), 32'h0);
        check("rand_activity", 32'(done > 40), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
